kernel_line_buffer: RTL and testbench

Streaming line buffer that turns a raster pixel stream (one 16-bit pixel per valid cycle) into a vertical column of KERNEL_SIZE pixels per pixel position. It sits directly upstream of vertex_detection and drives its `data_in`, `hcount_in`, `vcount_in` and `data_valid_in`. It stores the last KERNEL_SIZE-1 lines in rotating line RAMs and re-tags each column with the coordinates of the kernel's centre row.

---
 rtl/vision_pkg.sv | 20 ++
 rtl/line_ram.sv | 20 ++
 rtl/kernel_line_buffer.sv | 87 ++++++++
 tb/tb_kernel_line_buffer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared vision pipeline definitions: kernel geometry, frame size and pixel/column types.
package vision_pkg;
  localparam int unsigned KERNEL_SIZE = 11;
  localparam int unsigned HRES        = 1280;
  localparam int unsigned VRES        = 720;
  localparam int unsigned HALF_KERNEL = (KERNEL_SIZE - 1) / 2;
  localparam int unsigned PTR_W       = $clog2(KERNEL_SIZE);
  localparam int unsigned ADDR_W      = $clog2(HRES);

  typedef logic [15:0] pixel_t;
  typedef pixel_t [KERNEL_SIZE-1:0] column_t;

  // Row at the kernel centre; rows above the frame top wrap into the previous frame.
  function automatic logic [9:0] centre_row(input logic [9:0] vcount);
    logic signed [10:0] row;
    row = $signed({1'b0, vcount}) - $signed(11'(HALF_KERNEL));
    if (row < 0) row = row + $signed(11'(VRES));
    return row[9:0];
  endfunction
endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: simple dual-port, single clock, two-cycle registered read.
module line_ram
  import vision_pkg::*;
(
  input  logic              clk_in,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pixel_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output pixel_t            rdata
);
  pixel_t mem [HRES];
  pixel_t rd_q;

  always_ff @(posedge clk_in) begin
    if (we) mem[waddr] <= wdata;
    rd_q  <= mem[raddr];
    rdata <= rd_q;
  end
endmodule

// File: rtl/kernel_line_buffer.sv
// Turns a raster pixel stream into KERNEL_SIZE-tall columns tagged with the kernel centre row.
module kernel_line_buffer
  import vision_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  pixel_t      pixel_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        data_valid_in,
  output column_t     data_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        data_valid_out
);
  logic [PTR_W-1:0]       wptr;
  logic [KERNEL_SIZE-1:0] filled;
  pixel_t                 ram_q [KERNEL_SIZE];

  logic                   v1, v2;
  pixel_t                 pix1, pix2;
  logic [10:0]            h1, h2;
  logic [9:0]             vc1, vc2;
  logic [PTR_W-1:0]       wp1, wp2;
  logic [KERNEL_SIZE-1:0] fill1, fill2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wptr   <= '0;
      filled <= '0;
    end else if (data_valid_in && hcount_in == 11'(HRES - 1)) begin
      filled[wptr] <= 1'b1;
      wptr         <= (wptr == PTR_W'(KERNEL_SIZE - 1)) ? '0 : wptr + 1'b1;
    end
  end

  for (genvar g = 0; g < KERNEL_SIZE; g++) begin : g_ram
    line_ram u_ram (
      .clk_in (clk_in),
      .we     (data_valid_in && wptr == PTR_W'(g)),
      .waddr  (hcount_in),
      .wdata  (pixel_in),
      .raddr  (hcount_in),
      .rdata  (ram_q[g])
    );
  end

  // Side-band fields travel alongside the two-cycle RAM read; only valid bits need reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= data_valid_in;
      v2 <= v1;
    end
    pix1  <= pixel_in;
    pix2  <= pix1;
    h1    <= hcount_in;
    h2    <= h1;
    vc1   <= centre_row(vcount_in);
    vc2   <= vc1;
    wp1   <= wptr;
    wp2   <= wp1;
    fill1 <= filled;
    fill2 <= fill1;
  end

  // The RAM being written is never used; the current row comes from the bypass path.
  always_comb begin
    int unsigned idx;
    data_out       = '0;
    hcount_out     = '0;
    vcount_out     = '0;
    data_valid_out = v2;
    idx            = 0;
    if (v2) begin
      hcount_out                = h2;
      vcount_out                = vc2;
      data_out[KERNEL_SIZE-1]   = pix2;
      for (int unsigned j = 1; j < KERNEL_SIZE; j++) begin
        idx = (32'(wp2) + KERNEL_SIZE - j) % KERNEL_SIZE;
        data_out[PTR_W'(KERNEL_SIZE - 1 - j)] = fill2[PTR_W'(idx)] ? ram_q[PTR_W'(idx)] : '0;
      end
    end
  end
endmodule

// File: tb/tb_kernel_line_buffer.sv
// Scoreboard bench for kernel_line_buffer: driver queues expected columns, monitor checks outputs.
module tb_kernel_line_buffer;
  import vision_pkg::*;

  logic        clk;
  logic        rst_in;
  pixel_t      pixel_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        data_valid_in;
  column_t     data_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        data_valid_out;

  kernel_line_buffer dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .pixel_in       (pixel_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .data_out       (data_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .data_valid_out (data_valid_out)
  );

  typedef struct {
    column_t     col;
    logic [10:0] h;
    logic [9:0]  vc;
    int          issue;
    int          spot;
  } exp_t;

  exp_t exp_q[$];
  int   hist[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic pixel_t pix(input int v, input int h);
    return pixel_t'(v * 256 + (h % 256));
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  task automatic send(input int v, input int h, input bit valid, input int spot);
    exp_t e;
    pixel_in      = valid ? pix(v, h) : 16'hDEAD;
    hcount_in     = 11'(h);
    vcount_in     = 10'(v);
    data_valid_in = valid;
    if (valid) begin
      e.col[KERNEL_SIZE-1] = pix(v, h);
      for (int j = 1; j < int'(KERNEL_SIZE); j++)
        e.col[KERNEL_SIZE-1-j] = (hist.size() >= j) ? pix(hist[hist.size()-j], h) : 16'h0000;
      e.h     = 11'(h);
      e.vc    = 10'((v + int'(VRES) - int'(HALF_KERNEL)) % int'(VRES));
      e.issue = cyc;
      e.spot  = spot;
      exp_q.push_back(e);
      if (h == int'(HRES) - 1) hist.push_back(v);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_line(input int v, input int last_h, input bit gap, input int spot_h, input int spot_id);
    for (int h = 0; h <= last_h; h++) begin
      send(v, h, 1'b1, (h == spot_h) ? spot_id : 0);
      if (gap) send(v, h, 1'b0, 0);
    end
  endtask

  // The input sampled on the edge just before reset never emerges.
  task automatic do_reset(input string tag);
    rst_in        = 1'b1;
    data_valid_in = 1'b0;
    while (exp_q.size() > 0 && exp_q[$].issue >= cyc - 1) void'(exp_q.pop_back());
    hist.delete();
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid"},  data_valid_out, 0);
    chk({tag, "_data"},   data_out, 0);
    chk({tag, "_hcount"}, hcount_out, 0);
    chk({tag, "_vcount"}, vcount_out, 0);
    @(posedge clk);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic spot_check(input int id);
    case (id)
      1: begin
        chk("spot1_cur", data_out[10], 16'd37);
        chk("spot1_old", data_out[9:0], 0);
        chk("spot1_h", hcount_out, 11'd37);
        chk("spot1_v", vcount_out, 10'd715);
      end
      2: begin
        for (int j = 0; j < int'(KERNEL_SIZE); j++)
          chk($sformatf("spot2_col%0d", j), data_out[j], 16'(j * 256 + 37));
        chk("spot2_v", vcount_out, 10'd5);
      end
      3: begin
        chk("spot3_old", data_out[0], 16'h0225);
        chk("spot3_cur", data_out[10], 16'h0C25);
      end
      4: begin
        chk("spot4_old", data_out[0], 16'h0325);
        chk("spot4_cur", data_out[10], 16'h0D25);
      end
      5: begin
        chk("spot5_old", data_out[9:0], 0);
        chk("spot5_cur", data_out[10], 16'd37);
      end
      6: begin
        chk("spot6_prev", data_out[9], 16'hCF05);
        chk("spot6_old", data_out[0], 16'hC605);
        chk("spot6_v", vcount_out, 10'd715);
      end
      default: ;
    endcase
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (data_valid_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=1 expected=0 at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc, e.issue + 2);
          chk("column", data_out, e.col);
          chk("hcount", hcount_out, e.h);
          chk("vcount", vcount_out, e.vc);
          if (e.spot != 0) spot_check(e.spot);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_in        = 1'b1;
    data_valid_in = 1'b0;
    pixel_in      = '0;
    hcount_in     = '0;
    vcount_in     = '0;
    @(posedge clk);
    #1;
    do_reset("init");
    for (int v = 0; v <= 12; v++)
      send_line(v, int'(HRES) - 1, 1'b0, 37, (v == 0) ? 1 : (v == 10) ? 2 : (v == 12) ? 3 : 0);
    send_line(13, int'(HRES) - 1, 1'b1, 37, 4);
    send_line(3, 600, 1'b0, -1, 0);
    do_reset("midline");
    send_line(0, int'(HRES) - 1, 1'b0, 37, 5);
    for (int v = 709; v <= 719; v++)
      send_line(v, int'(HRES) - 1, 1'b0, -1, 0);
    send_line(0, 20, 1'b0, 5, 6);
    for (int i = 0; i < 6; i++) send(0, 0, 1'b0, 0);
    chk("drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
